// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the ID/EX/MM stages and the per-stage
// register control codes, fetch PC control and stall status returned to the pipeline
interface pipe_hazard_ctrl_if #(
   parameter int RIDX_W = 4,
   parameter int CNT_W  = 32
);
   logic [RIDX_W-1:0] id_src_x, id_src_y, ex_dst;
   logic id_use_x, id_use_y, ex_is_load, ex_br_taken, mm_req, mm_ready;
   logic [1:0] ctrl_ifid, ctrl_idex, ctrl_exmm, ctrl_mmwb;
   logic pc_hold, pc_redirect, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output id_src_x, id_src_y, id_use_x, id_use_y, ex_dst, ex_is_load, ex_br_taken, mm_req, mm_ready,
      input  ctrl_ifid, ctrl_idex, ctrl_exmm, ctrl_mmwb, pc_hold, pc_redirect, mem_err, stall_cnt
   );
   modport slave (
      input  id_src_x, id_src_y, id_use_x, id_use_y, ex_dst, ex_is_load, ex_br_taken, mm_req, mm_ready,
      output ctrl_ifid, ctrl_idex, ctrl_exmm, ctrl_mmwb, pc_hold, pc_redirect, mem_err, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage PASS/HOLD/FLUSH codes and fetch PC control for
// load-use hazards, taken branches resolved in EX and multi-cycle data-cache accesses
module pipe_hazard_ctrl #(
   parameter int RIDX_W   = 4,
   parameter int LU_STALL = 1,
   parameter int MEM_TMO  = 64,
   parameter int CNT_W    = 32
) (
   input logic clk,
   input logic rst,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] RUN = 2'd0, LU_WAIT = 2'd1, MEM_WAIT = 2'd2;
   localparam logic [1:0] PASS = 2'b00, HOLD = 2'b01, FLUSH = 2'b10;
   localparam logic [2:0] LU_INIT = 3'(LU_STALL - 1);
   localparam logic [7:0] TMO = 8'(MEM_TMO);
   logic [1:0] state, state_nx;
   logic [2:0] lu_cnt, lu_cnt_nx;
   logic [7:0] wait_cnt, wait_cnt_nx;
   logic [CNT_W-1:0] stall_q;
   logic [7:0] ctrl;
   logic lu, ms, tmo, hold, redir, err_q;
   assign lu = bus.ex_is_load && bus.ex_dst != RIDX_W'(0) &&
               ((bus.id_use_x && bus.id_src_x == bus.ex_dst) || (bus.id_use_y && bus.id_src_y == bus.ex_dst));
   assign ms = bus.mm_req && !bus.mm_ready;
   assign tmo = state == MEM_WAIT && !bus.mm_ready && wait_cnt == TMO;
   // A timeout abandons any pending load-use bubbles; a normal cache completion resumes them.
   always_comb begin
      ctrl = {PASS, PASS, PASS, PASS};
      {hold, redir} = 2'b00;
      {state_nx, lu_cnt_nx, wait_cnt_nx} = {state, lu_cnt, wait_cnt};
      if (state == MEM_WAIT) begin
         if (bus.mm_ready || tmo) begin
            state_nx = (tmo || lu_cnt == 3'd0) ? RUN : LU_WAIT;
            lu_cnt_nx = tmo ? 3'd0 : lu_cnt;
            wait_cnt_nx = 8'd0;
         end else begin
            {ctrl, hold} = {HOLD, HOLD, HOLD, FLUSH, 1'b1};
            wait_cnt_nx = wait_cnt + 8'd1;
         end
      end else if (ms) begin
         {ctrl, hold} = {HOLD, HOLD, HOLD, FLUSH, 1'b1};
         state_nx = MEM_WAIT;
         wait_cnt_nx = 8'd1;
      end else if (state == LU_WAIT) begin
         {ctrl, hold} = {HOLD, FLUSH, PASS, PASS, 1'b1};
         state_nx = lu_cnt == 3'd1 ? RUN : LU_WAIT;
         lu_cnt_nx = lu_cnt - 3'd1;
      end else if (bus.ex_br_taken) begin
         {ctrl, redir} = {FLUSH, FLUSH, PASS, PASS, 1'b1};
      end else if (lu) begin
         {ctrl, hold} = {HOLD, FLUSH, PASS, PASS, 1'b1};
         state_nx = LU_STALL > 1 ? LU_WAIT : RUN;
         lu_cnt_nx = LU_INIT;
      end
      if (rst) {ctrl, hold, redir} = '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         lu_cnt <= '0;
         wait_cnt <= '0;
         err_q <= 1'b0;
         stall_q <= '0;
      end else begin
         state <= state_nx;
         lu_cnt <= lu_cnt_nx;
         wait_cnt <= wait_cnt_nx;
         err_q <= err_q | tmo;
         if (hold && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      end
   end
   assign {bus.ctrl_ifid, bus.ctrl_idex, bus.ctrl_exmm, bus.ctrl_mmwb} = ctrl;
   assign bus.pc_hold = hold;
   assign bus.pc_redirect = redir;
   assign bus.mem_err = err_q;
   assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of the hazard controller; instance a has a short
// memory timeout, b a three-cycle load-use stall, c a two-bit stall counter
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] id_src_x, id_src_y, ex_dst;
   logic id_use_x, id_use_y, ex_is_load, ex_br_taken, mm_req, mm_ready;
   logic [17:0] in_vec;
   logic [9:0] a_o, b_o, c_o;
   logic [31:0] a_stall, b_stall;
   int errors = 0;
   int checks = 0;
   // {ifid, idex, exmm, mmwb, pc_hold, pc_redirect}
   localparam logic [9:0] O_IDLE = 10'b00_00_00_00_0_0;
   localparam logic [9:0] O_LU   = 10'b01_10_00_00_1_0;
   localparam logic [9:0] O_BR   = 10'b10_10_00_00_0_1;
   localparam logic [9:0] O_MEM  = 10'b01_01_01_10_1_0;
   pipe_hazard_ctrl_if #(.RIDX_W(4), .CNT_W(32)) a_if ();
   pipe_hazard_ctrl_if #(.RIDX_W(4), .CNT_W(32)) b_if ();
   pipe_hazard_ctrl_if #(.RIDX_W(4), .CNT_W(2)) c_if ();
   pipe_hazard_ctrl #(.RIDX_W(4), .LU_STALL(1), .MEM_TMO(4), .CNT_W(32)) u_a (.clk(clk), .rst(rst), .bus(a_if));
   pipe_hazard_ctrl #(.RIDX_W(4), .LU_STALL(3), .MEM_TMO(64), .CNT_W(32)) u_b (.clk(clk), .rst(rst), .bus(b_if));
   pipe_hazard_ctrl #(.RIDX_W(4), .LU_STALL(1), .MEM_TMO(64), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(c_if));
   always #5 clk = ~clk;
   assign in_vec = {id_src_x, id_src_y, ex_dst, id_use_x, id_use_y, ex_is_load, ex_br_taken, mm_req, mm_ready};
   assign {a_if.id_src_x, a_if.id_src_y, a_if.ex_dst, a_if.id_use_x, a_if.id_use_y, a_if.ex_is_load, a_if.ex_br_taken, a_if.mm_req, a_if.mm_ready} = in_vec;
   assign {b_if.id_src_x, b_if.id_src_y, b_if.ex_dst, b_if.id_use_x, b_if.id_use_y, b_if.ex_is_load, b_if.ex_br_taken, b_if.mm_req, b_if.mm_ready} = in_vec;
   assign {c_if.id_src_x, c_if.id_src_y, c_if.ex_dst, c_if.id_use_x, c_if.id_use_y, c_if.ex_is_load, c_if.ex_br_taken, c_if.mm_req, c_if.mm_ready} = in_vec;
   assign a_o = {a_if.ctrl_ifid, a_if.ctrl_idex, a_if.ctrl_exmm, a_if.ctrl_mmwb, a_if.pc_hold, a_if.pc_redirect};
   assign b_o = {b_if.ctrl_ifid, b_if.ctrl_idex, b_if.ctrl_exmm, b_if.ctrl_mmwb, b_if.pc_hold, b_if.pc_redirect};
   assign c_o = {c_if.ctrl_ifid, c_if.ctrl_idex, c_if.ctrl_exmm, c_if.ctrl_mmwb, c_if.pc_hold, c_if.pc_redirect};

   task automatic idle();
      {id_src_x, id_src_y, ex_dst, id_use_x, id_use_y, ex_is_load, ex_br_taken, mm_req, mm_ready} = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [3:0] r);
      ex_is_load = 1'b1;
      ex_dst = r;
      id_use_x = 1'b1;
      id_src_x = r;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      ex_br_taken = 1'b1;
      mm_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (a_o !== O_IDLE || b_o !== O_IDLE) begin
            errors++;
            $display("FAIL reset_outputs[%0d]: a=%b b=%b, want %b", i, a_o, b_o, O_IDLE);
         end
      end
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE || a_if.stall_cnt !== 32'd0 || b_if.stall_cnt !== 32'd0 || a_if.mem_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: a=%b stall=%0d/%0d err=%b, want %b 0/0 0", a_o, a_if.stall_cnt, b_if.stall_cnt, a_if.mem_err, O_IDLE);
      end
      a_stall = 0;
      b_stall = 0;
   endtask

   task automatic test_load_use();
      // {load, dst, use_x, src_x, use_y, src_y, stall expected}
      logic [15:0] tv [6];
      tv = '{{1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1},
             {1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0},
             {1'b1, 4'd7, 1'b0, 4'd7, 1'b1, 4'd7, 1'b1},
             {1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 4'd7, 1'b0},
             {1'b0, 4'd5, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0},
             {1'b1, 4'd9, 1'b1, 4'd8, 1'b1, 4'd3, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         tick();
         idle();
         {ex_is_load, ex_dst, id_use_x, id_src_x, id_use_y, id_src_y} = tv[i][15:1];
         a_stall += 32'(tv[i][0]);
         @(negedge clk);
         checks++;
         if (a_o !== (tv[i][0] ? O_LU : O_IDLE)) begin
            errors++;
            $display("FAIL load_use[%0d]: got %b, want %b", i, a_o, tv[i][0] ? O_LU : O_IDLE);
         end
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE || a_if.stall_cnt !== a_stall) begin
         errors++;
         $display("FAIL load_use_stall_cnt: out=%b cnt=%0d, want %b %0d", a_o, a_if.stall_cnt, O_IDLE, a_stall);
      end
   endtask

   task automatic test_branch_lu();
      tick();
      idle();
      set_lu(4'd5);
      ex_br_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (a_o !== O_BR) begin
         errors++;
         $display("FAIL branch_over_lu: got %b, want %b", a_o, O_BR);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE || a_if.stall_cnt !== a_stall) begin
         errors++;
         $display("FAIL branch_stall_cnt: out=%b cnt=%0d, want %b %0d", a_o, a_if.stall_cnt, O_IDLE, a_stall);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp [5];
      exp = '{O_BR, O_LU, O_IDLE, O_BR, O_IDLE};
      for (int i = 0; i < 5; i++) begin
         tick();
         idle();
         if (i == 0 || i == 3) ex_br_taken = 1'b1;
         if (i == 1) set_lu(4'd12);
         if (i == 2) {mm_req, mm_ready} = 2'b11;
         @(negedge clk);
         checks++;
         if (a_o !== exp[i]) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got %b, want %b", i, a_o, exp[i]);
         end
      end
      a_stall += 1;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (a_if.stall_cnt !== a_stall) begin
         errors++;
         $display("FAIL back_to_back_stall_cnt: got %0d, want %0d", a_if.stall_cnt, a_stall);
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 4; i++) begin
         tick();
         idle();
         {mm_req, mm_ready, ex_br_taken} = {1'b1, i == 3, 1'b1};
         @(negedge clk);
         checks++;
         if (a_o !== (i == 3 ? O_IDLE : O_MEM)) begin
            errors++;
            $display("FAIL mem_wait[%0d]: got %b, want %b", i, a_o, i == 3 ? O_IDLE : O_MEM);
         end
      end
      a_stall += 3;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE || a_if.stall_cnt !== a_stall || a_if.mem_err !== 1'b0) begin
         errors++;
         $display("FAIL mem_wait_exit: out=%b cnt=%0d err=%b, want %b %0d 0", a_o, a_if.stall_cnt, a_if.mem_err, O_IDLE, a_stall);
      end
   endtask

   task automatic test_timeout();
      // 0-3 stall, 4 times out and releases, 5 stalls again, 6 completes, 7 stalls, 8 reset mid-wait
      logic [9:0] exp [8];
      logic [7:0] err_exp;
      exp = '{O_MEM, O_MEM, O_MEM, O_MEM, O_IDLE, O_MEM, O_IDLE, O_MEM};
      err_exp = 8'b1110_0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         idle();
         {mm_req, mm_ready} = {1'b1, i == 6};
         @(negedge clk);
         checks++;
         if (a_o !== exp[i] || a_if.mem_err !== err_exp[i]) begin
            errors++;
            $display("FAIL timeout[%0d]: out=%b err=%b, want %b %b", i, a_o, a_if.mem_err, exp[i], err_exp[i]);
         end
      end
      a_stall += 5;
      checks++;
      if (a_if.stall_cnt !== a_stall) begin
         errors++;
         $display("FAIL timeout_stall_cnt: got %0d, want %0d", a_if.stall_cnt, a_stall);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE) begin
         errors++;
         $display("FAIL reset_mid_wait: got %b, want %b", a_o, O_IDLE);
      end
      tick();
      rst = 1'b0;
      idle();
      @(negedge clk);
      checks++;
      if (a_o !== O_IDLE || a_if.mem_err !== 1'b0 || a_if.stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_after_timeout: out=%b err=%b cnt=%0d, want %b 0 0", a_o, a_if.mem_err, a_if.stall_cnt, O_IDLE);
      end
      a_stall = 0;
      b_stall = 0;
   endtask

   task automatic test_lu_stall3();
      logic [9:0] exp [7];
      exp = '{O_LU, O_MEM, O_MEM, O_IDLE, O_LU, O_LU, O_IDLE};
      for (int i = 0; i < 7; i++) begin
         tick();
         idle();
         if (i == 0) set_lu(4'd5);
         if (i >= 1 && i <= 3) {mm_req, mm_ready} = {1'b1, i == 3};
         @(negedge clk);
         checks++;
         if (b_o !== exp[i]) begin
            errors++;
            $display("FAIL lu_stall3[%0d]: got %b, want %b", i, b_o, exp[i]);
         end
      end
      b_stall = 5;
      checks++;
      if (b_if.stall_cnt !== b_stall) begin
         errors++;
         $display("FAIL lu_stall3_stall_cnt: got %0d, want %0d", b_if.stall_cnt, b_stall);
      end
   endtask

   task automatic test_saturate();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         idle();
         {mm_req, mm_ready} = {1'b1, i == 5};
         tick();
      end
      idle();
      @(negedge clk);
      checks++;
      if (c_if.stall_cnt !== 2'b11 || c_o !== O_IDLE) begin
         errors++;
         $display("FAIL stall_cnt_saturate: cnt=%b out=%b, want 11 %b", c_if.stall_cnt, c_o, O_IDLE);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_lu();
      test_back_to_back();
      test_mem_wait();
      test_timeout();
      test_lu_stall3();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
